// File: rtl/mat_operand_loader.sv
// Byte-serial operand loader for the 2x2 matrix stage: packs A/B, waits out the
// matrix pipeline latency, captures its result and returns it on a valid/ready port.
module mat_operand_loader #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned LATENCY = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [4*WIDTH-1:0]   A_out,
  output logic [4*WIDTH-1:0]   B_out,
  input  logic [63:0]          res_in,
  output logic [63:0]          out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy
);

  localparam int unsigned VW  = 4 * WIDTH;
  localparam int unsigned WCW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int unsigned CW  = 3;

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   elem_cnt_q, elem_cnt_d;
  logic [WCW-1:0]  wait_cnt_q, wait_cnt_d;
  logic [VW-1:0]   a_q, a_d;
  logic [VW-1:0]   b_q, b_d;
  logic [63:0]     res_q, res_d;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_LOAD;
      elem_cnt_q <= '0;
      wait_cnt_q <= '0;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
    end else begin
      state_q    <= state_d;
      elem_cnt_q <= elem_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      res_q      <= res_d;
    end
  end

  // Next-state and slot update; every register holds unless its state updates it
  always_comb begin
    state_d    = state_q;
    elem_cnt_d = elem_cnt_q;
    wait_cnt_d = wait_cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    res_d      = res_q;

    unique case (state_q)
      S_LOAD: begin
        if (in_valid) begin
          // elem_cnt[2] picks the matrix, elem_cnt[1:0] the slot (slot 0 in the MSBs)
          for (int unsigned s = 0; s < 4; s++) begin
            if (elem_cnt_q[1:0] == 2'(s)) begin
              if (elem_cnt_q[2]) b_d[WIDTH*(3-s) +: WIDTH] = in_data;
              else               a_d[WIDTH*(3-s) +: WIDTH] = in_data;
            end
          end
          elem_cnt_d = elem_cnt_q + CW'(1);
          if (elem_cnt_q == CW'(7)) begin
            wait_cnt_d = '0;
            state_d    = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (wait_cnt_q == WCW'(LATENCY - 1)) begin
          res_d   = res_in;
          state_d = S_OUT;
        end else begin
          wait_cnt_d = wait_cnt_q + WCW'(1);
        end
      end
      S_OUT: begin
        if (out_ready) state_d = S_LOAD;
      end
      default: state_d = S_LOAD;
    endcase
  end

  assign in_ready  = (state_q == S_LOAD);
  assign busy      = (state_q != S_LOAD);
  assign out_valid = (state_q == S_OUT);
  assign A_out     = a_q;
  assign B_out     = b_q;
  assign out_data  = res_q;

endmodule
